// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
// Opcode/funct values, ALU codes, select encodings, state and class enums.
package mips_multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_e;

   typedef enum logic [3:0] {
      C_NOP, C_R, C_JR, C_IALU,
      C_LW, C_LB, C_LBU, C_SW, C_SB,
      C_BEQ, C_BNE, C_J, C_JAL
   } cls_e;

   // Latched per-instruction control: class plus ALU code and extend mode
   typedef struct packed {
      cls_e       cls;
      logic [5:0] alu;
      logic       zext;
   } ictl_t;

   localparam logic [5:0] OP_R     = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   // R-type ALU codes equal funct; these cover the non-R cases
   localparam logic [5:0] ALU_ADD = FN_ADDU;
   localparam logic [5:0] ALU_BEQ = 6'h04;
   localparam logic [5:0] ALU_BNE = 6'h05;
   localparam logic [5:0] ALU_LUI = 6'h0F;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;
   localparam logic [1:0] PC_JR  = 2'd3;

   localparam logic [1:0] RD_RT  = 2'd0;
   localparam logic [1:0] RD_RD  = 2'd1;
   localparam logic [1:0] RD_R31 = 2'd2;

   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_MEM = 2'd1;
   localparam logic [1:0] M2R_PC4 = 2'd2;

   localparam ictl_t CTL_NOP = '{cls: C_NOP, alu: 6'h00, zext: 1'b0};

endpackage

// File: rtl/mips_multicycle_ctrl_op_decode.sv
// Combinational opcode/funct decoder for the multi-cycle control unit.
// Produces the instruction class bundle; unknown encodings flag illegal.
module mips_multicycle_ctrl_op_decode
   import mips_multicycle_ctrl_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [5:0] funct_i,
   output ictl_t      ctl_o,
   output logic       illegal_o
);

   // Map the instruction word fields onto a class and its ALU code
   always_comb begin
      ctl_o     = CTL_NOP;
      illegal_o = 1'b0;
      unique case (opcode_i)
         OP_R: begin
            unique case (funct_i)
               FN_ADDU, FN_SUBU, FN_AND, FN_OR,
               FN_XOR, FN_NOR, FN_SLT, FN_SLTU,
               FN_SLL, FN_SRL, FN_SRA: begin
                  ctl_o.cls = C_R;
                  ctl_o.alu = funct_i;
               end
               FN_JR:   ctl_o.cls = C_JR;
               default: illegal_o = 1'b0 | 1'b1;
            endcase
         end
         OP_ADDIU: ctl_o = '{cls: C_IALU, alu: FN_ADDU, zext: 1'b0};
         OP_SLTI:  ctl_o = '{cls: C_IALU, alu: FN_SLT,  zext: 1'b0};
         OP_SLTIU: ctl_o = '{cls: C_IALU, alu: FN_SLTU, zext: 1'b0};
         OP_ANDI:  ctl_o = '{cls: C_IALU, alu: FN_AND,  zext: 1'b1};
         OP_ORI:   ctl_o = '{cls: C_IALU, alu: FN_OR,   zext: 1'b1};
         OP_XORI:  ctl_o = '{cls: C_IALU, alu: FN_XOR,  zext: 1'b1};
         OP_LUI:   ctl_o = '{cls: C_IALU, alu: ALU_LUI, zext: 1'b0};
         OP_LW:    ctl_o = '{cls: C_LW,   alu: ALU_ADD, zext: 1'b0};
         OP_LB:    ctl_o = '{cls: C_LB,   alu: ALU_ADD, zext: 1'b0};
         OP_LBU:   ctl_o = '{cls: C_LBU,  alu: ALU_ADD, zext: 1'b0};
         OP_SW:    ctl_o = '{cls: C_SW,   alu: ALU_ADD, zext: 1'b0};
         OP_SB:    ctl_o = '{cls: C_SB,   alu: ALU_ADD, zext: 1'b0};
         OP_BEQ:   ctl_o = '{cls: C_BEQ,  alu: ALU_BEQ, zext: 1'b0};
         OP_BNE:   ctl_o = '{cls: C_BNE,  alu: ALU_BNE, zext: 1'b0};
         OP_J:     ctl_o.cls = C_J;
         OP_JAL:   ctl_o.cls = C_JAL;
         default:  illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/exec/mem/wb,
// stalls on the data memory handshake and counts retired instructions.
module mips_multicycle_ctrl
   import mips_multicycle_ctrl_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter bit HALT_ILL = 1'b0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             alu_branch,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             ir_write,
   output logic [1:0]       reg_dst,
   output logic             reg_write,
   output logic [1:0]       mem_to_reg,
   output logic             alu_src,
   output logic             ext_zero,
   output logic [5:0]       alu_op,
   output logic             mem_re,
   output logic             mem_we,
   output logic [1:0]       mem_size,
   output logic             illegal,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_e           state_q;
   ictl_t            ctl_q;
   ictl_t            dec_ctl;
   logic             dec_ill;
   logic [CNT_W-1:0] retired_q;
   logic             is_load;
   logic             is_store;
   logic             is_byte;

   mips_multicycle_ctrl_op_decode u_dec (
      .opcode_i  (opcode),
      .funct_i   (funct),
      .ctl_o     (dec_ctl),
      .illegal_o (dec_ill)
   );

   assign is_load  = ctl_q.cls inside {C_LW, C_LB, C_LBU};
   assign is_store = ctl_q.cls inside {C_SW, C_SB};
   assign is_byte  = ctl_q.cls inside {C_LB, C_LBU, C_SB};
   assign retired  = retired_q;

   // State, latched class and retire counter; reset abandons any instruction
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         ctl_q     <= CTL_NOP;
         retired_q <= '0;
      end else begin
         if (pc_write) retired_q <= retired_q + ONE;
         unique case (state_q)
            S_FETCH:  state_q <= S_DECODE;
            S_DECODE: begin
               ctl_q   <= dec_ctl;
               state_q <= (dec_ill && HALT_ILL) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
               unique case (ctl_q.cls)
                  C_LW, C_LB, C_LBU,
                  C_SW, C_SB:        state_q <= S_MEM;
                  C_R, C_IALU, C_JAL: state_q <= S_WB;
                  default:           state_q <= S_FETCH;
               endcase
            end
            S_MEM: begin
               if (mem_ready) state_q <= is_load ? S_WB : S_FETCH;
            end
            S_WB:    state_q <= S_FETCH;
            S_HALT:  state_q <= S_HALT;
            default: state_q <= S_FETCH;
         endcase
      end
   end

   // Datapath controls from state and latched class
   always_comb begin
      pc_write   = 1'b0;
      pc_src     = PC_SEQ;
      ir_write   = 1'b0;
      reg_dst    = RD_RT;
      reg_write  = 1'b0;
      mem_to_reg = M2R_ALU;
      alu_src    = 1'b0;
      ext_zero   = 1'b0;
      alu_op     = 6'h00;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      mem_size   = SZ_BYTE;
      illegal    = 1'b0;
      halted     = 1'b0;
      unique case (state_q)
         S_DECODE: begin
            ir_write = 1'b1;
            illegal  = dec_ill;
         end
         S_EXEC: begin
            alu_op   = ctl_q.alu;
            ext_zero = ctl_q.zext;
            alu_src  = is_load || is_store || ctl_q.cls == C_IALU;
            unique case (ctl_q.cls)
               C_BEQ, C_BNE: begin
                  pc_write = 1'b1;
                  pc_src   = alu_branch ? PC_BR : PC_SEQ;
               end
               C_J: begin
                  pc_write = 1'b1;
                  pc_src   = PC_JMP;
               end
               C_JR: begin
                  pc_write = 1'b1;
                  pc_src   = PC_JR;
               end
               C_NOP:   pc_write = 1'b1;
               default: ;
            endcase
         end
         S_MEM: begin
            alu_op   = ALU_ADD;
            alu_src  = 1'b1;
            mem_size = is_byte ? SZ_BYTE : SZ_WORD;
            mem_re   = is_load;
            mem_we   = is_store;
            pc_write = is_store && mem_ready;
         end
         S_WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            unique case (ctl_q.cls)
               C_R: reg_dst = RD_RD;
               C_LW, C_LB, C_LBU: mem_to_reg = M2R_MEM;
               C_JAL: begin
                  reg_dst    = RD_R31;
                  mem_to_reg = M2R_PC4;
                  pc_src     = PC_JMP;
               end
               default: ;
            endcase
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Random-instruction bench for the multi-cycle MIPS control unit.
// A reference model expands each instruction into per-cycle expected controls.
module tb_mips_multicycle_ctrl;
   import mips_multicycle_ctrl_pkg::*;

   typedef struct packed {
      logic       pcw;
      logic [1:0] pcs;
      logic       irw;
      logic [1:0] rdst;
      logic       rw;
      logic [1:0] m2r;
      logic       asrc;
      logic       ez;
      logic [5:0] aop;
      logic       re;
      logic       we;
      logic [1:0] sz;
      logic       ill;
      logic       hlt;
   } ov_t;

   typedef struct {
      ov_t o;
      int  ret;
   } exp_t;

   typedef enum {
      K_ILL, K_R, K_JR, K_IALU, K_LOAD, K_STORE, K_BR, K_J, K_JAL
   } kind_e;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  opcode = '0;
   logic [5:0]  funct = '0;
   logic        alu_branch = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_write, ir_write, reg_write, alu_src, ext_zero;
   logic        mem_re, mem_we, illegal, halted;
   logic [1:0]  pc_src, reg_dst, mem_to_reg, mem_size;
   logic [5:0]  alu_op;
   logic [31:0] retired;
   ov_t         got;

   int   ncmp = 0;
   int   nerr = 0;
   int   ret_m = 0;
   bit   mon_en = 1'b0;
   exp_t q[$];

   always #5 clock = ~clock;

   mips_multicycle_ctrl #(.CNT_W(32), .HALT_ILL(1'b0)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
      .alu_branch(alu_branch), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
      .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .alu_src(alu_src), .ext_zero(ext_zero), .alu_op(alu_op),
      .mem_re(mem_re), .mem_we(mem_we), .mem_size(mem_size),
      .illegal(illegal), .halted(halted), .retired(retired)
   );

   assign got = {pc_write, pc_src, ir_write, reg_dst, reg_write,
                 mem_to_reg, alu_src, ext_zero, alu_op, mem_re,
                 mem_we, mem_size, illegal, halted};

   function automatic kind_e kind_of(input logic [5:0] op,
                                     input logic [5:0] fn);
      case (op)
         6'h00: begin
            case (fn)
               6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03: return K_R;
               6'h08: return K_JR;
               default: return K_ILL;
            endcase
         end
         6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: return K_IALU;
         6'h23, 6'h20, 6'h24: return K_LOAD;
         6'h2B, 6'h28: return K_STORE;
         6'h04, 6'h05: return K_BR;
         6'h02: return K_J;
         6'h03: return K_JAL;
         default: return K_ILL;
      endcase
   endfunction

   function automatic logic [5:0] ialu_code(input logic [5:0] op);
      case (op)
         6'h09: return 6'h21;
         6'h0A: return 6'h2A;
         6'h0B: return 6'h2B;
         6'h0C: return 6'h24;
         6'h0D: return 6'h25;
         6'h0E: return 6'h26;
         default: return ALU_LUI;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      ncmp++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // Expand one instruction into expected cycles, then drive it
   task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                        input bit br, input int w);
      kind_e k;
      ov_t   seq[$];
      ov_t   e;
      bit    mem;
      int    n;
      k = kind_of(op, fn);
      mem = (k == K_LOAD) || (k == K_STORE);
      e = '0;
      seq.push_back(e);
      e.irw = 1'b1;
      e.ill = (k == K_ILL);
      seq.push_back(e);
      e = '0;
      case (k)
         K_R: e.aop = fn;
         K_IALU: begin
            e.asrc = 1'b1;
            e.aop  = ialu_code(op);
            e.ez   = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
         end
         K_LOAD, K_STORE: begin
            e.asrc = 1'b1;
            e.aop  = 6'h21;
         end
         K_BR: begin
            e.aop = (op == 6'h04) ? ALU_BEQ : ALU_BNE;
            e.pcw = 1'b1;
            e.pcs = br ? 2'd1 : 2'd0;
         end
         K_J:   begin e.pcw = 1'b1; e.pcs = 2'd2; end
         K_JR:  begin e.pcw = 1'b1; e.pcs = 2'd3; end
         K_ILL: e.pcw = 1'b1;
         default: ;
      endcase
      seq.push_back(e);
      if (mem) begin
         for (int j = 0; j <= w; j++) begin
            e = '0;
            e.asrc = 1'b1;
            e.aop  = 6'h21;
            e.sz   = (op == 6'h23 || op == 6'h2B) ? 2'd2 : 2'd0;
            e.re   = (k == K_LOAD);
            e.we   = (k == K_STORE);
            e.pcw  = (j == w) && (k == K_STORE);
            seq.push_back(e);
         end
      end
      if (k inside {K_R, K_IALU, K_JAL, K_LOAD}) begin
         e = '0;
         e.rw  = 1'b1;
         e.pcw = 1'b1;
         if (k == K_R) e.rdst = 2'd1;
         if (k == K_LOAD) e.m2r = 2'd1;
         if (k == K_JAL) begin
            e.rdst = 2'd2;
            e.m2r  = 2'd2;
            e.pcs  = 2'd2;
         end
         seq.push_back(e);
      end
      foreach (seq[i]) q.push_back('{o: seq[i], ret: ret_m});
      ret_m++;
      n = seq.size();
      for (int c = 0; c < n; c++) begin
         opcode     = (c == 1) ? op : 6'($urandom);
         funct      = (c == 1) ? fn : 6'($urandom);
         alu_branch = (c == 2) ? br : 1'($urandom);
         if (mem && c >= 3 && c <= 3 + w) mem_ready = (c == 3 + w);
         else mem_ready = 1'($urandom);
         @(posedge clock);
         #1;
      end
   endtask

   // Scoreboard monitor: one expected entry per active cycle
   always @(negedge clock) begin
      exp_t x;
      if (mon_en && q.size() > 0) begin
         x = q.pop_front();
         ncmp++;
         if (got !== x.o || retired !== 32'(x.ret)) begin
            nerr++;
            $display("FAIL cycle: got %h ret %0d expected %h ret %0d",
                     got, retired, x.o, x.ret);
         end
      end
   end

   logic [5:0] ops[17] = '{6'h00, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                           6'h0E, 6'h0F, 6'h23, 6'h20, 6'h24, 6'h2B,
                           6'h28, 6'h04, 6'h05, 6'h02, 6'h03};
   logic [5:0] rfn[12] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                           6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};

   initial begin
      logic [5:0] op;
      logic [5:0] fn;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("reset_outs", 64'(got), 64'd0);
         chk("reset_retired", 64'(retired), 64'd0);
      end
      @(posedge clock);
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;
      issue(6'h00, 6'h21, 1'b0, 0);
      issue(6'h23, 6'h00, 1'b0, 2);
      issue(6'h04, 6'h00, 1'b1, 0);
      issue(6'h04, 6'h00, 1'b0, 0);
      issue(6'h03, 6'h00, 1'b0, 0);
      issue(6'h3F, 6'h00, 1'b0, 0);
      for (int i = 0; i < 250; i++) begin
         int r;
         r = $urandom_range(0, 19);
         op = (r < 17) ? ops[r] : 6'($urandom);
         if (op == 6'h00 && $urandom_range(0, 7) != 0)
            fn = rfn[$urandom_range(0, 11)];
         else
            fn = 6'($urandom);
         issue(op, fn, 1'($urandom), $urandom_range(0, 3));
      end
      mon_en = 1'b0;
      chk("queue_drained", 64'(q.size()), 64'd0);
      q.delete();
      opcode    = 6'h2B;
      funct     = 6'h00;
      mem_ready = 1'b0;
      repeat (3) begin
         @(posedge clock);
         #1;
      end
      #2;
      chk("sw_mem_we", 64'(mem_we), 64'd1);
      chk("sw_retired", 64'(retired), 64'(ret_m));
      reset = 1'b0;
      #1;
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_outs", 64'(got), 64'd0);
      chk("rst_retired", 64'(retired), 64'd0);
      ret_m = 0;
      @(posedge clock);
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;
      issue(6'h00, 6'h21, 1'b0, 0);
      issue(6'h2B, 6'h00, 1'b0, 1);
      mon_en = 1'b0;
      chk("final_queue", 64'(q.size()), 64'd0);
      chk("final_retired", 64'(retired), 64'd2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
